// File: rtl/hazard_stall_controller_pkg.sv
// Shared pipeline definitions for the hazard stall controller: FSM encodings,
// the hardwired-zero register and per-hazard stall counts.
package pipeline_defs;

    typedef enum logic {
        ST_RUN   = 1'b0,
        ST_STALL = 1'b1
    } state_e;

    localparam logic [4:0] REG_ZERO = 5'd0;

    localparam logic [1:0] STALL_LOADUSE    = 2'd1;
    localparam logic [1:0] STALL_BR_ALU     = 2'd1;
    localparam logic [1:0] STALL_BR_LOAD    = 2'd2;
    localparam logic [1:0] STALL_BR_MEMLOAD = 2'd1;

    // $0 is hardwired, so a write to it can never create a dependency.
    function automatic logic reg_match(input logic [4:0] dst,
                                       input logic [4:0] src,
                                       input logic       src_used);
        return (dst != REG_ZERO) && (dst == src) && src_used;
    endfunction

endpackage

// File: rtl/hazard_stall_controller_if.sv
// ID/EX/MEM hazard fields in, pipeline stall/flush controls out.
// StallCycles/FlushCount exist only when HAZARD_PERF_EN is defined.
interface hazard_stall_controller_if #(parameter int PERF_W = 32);
    logic [4:0] IIRs;
    logic [4:0] IIRt;
    logic       IDUseRt;
    logic       beq;
    logic       bne;
    logic       jump;
    logic       BrTaken;
    logic       IEMemRead;
    logic       IERegWrite;
    logic [4:0] IERd;
    logic       EMMemRead;
    logic [4:0] EMRd;
    logic       PCWrite;
    logic       IFIDWrite;
    logic       IDEXBubble;
    logic       IFIDFlush;
    logic       StallActive;
`ifdef HAZARD_PERF_EN
    logic [PERF_W-1:0] StallCycles;
    logic [PERF_W-1:0] FlushCount;

    modport master (
        output IIRs, IIRt, IDUseRt, beq, bne, jump, BrTaken,
        output IEMemRead, IERegWrite, IERd, EMMemRead, EMRd,
        input  PCWrite, IFIDWrite, IDEXBubble, IFIDFlush, StallActive,
        input  StallCycles, FlushCount
    );
    modport slave (
        input  IIRs, IIRt, IDUseRt, beq, bne, jump, BrTaken,
        input  IEMemRead, IERegWrite, IERd, EMMemRead, EMRd,
        output PCWrite, IFIDWrite, IDEXBubble, IFIDFlush, StallActive,
        output StallCycles, FlushCount
    );
`else
    modport master (
        output IIRs, IIRt, IDUseRt, beq, bne, jump, BrTaken,
        output IEMemRead, IERegWrite, IERd, EMMemRead, EMRd,
        input  PCWrite, IFIDWrite, IDEXBubble, IFIDFlush, StallActive
    );
    modport slave (
        input  IIRs, IIRt, IDUseRt, beq, bne, jump, BrTaken,
        input  IEMemRead, IERegWrite, IERd, EMMemRead, EMRd,
        output PCWrite, IFIDWrite, IDEXBubble, IFIDFlush, StallActive
    );
`endif
endinterface

// File: rtl/hazard_stall_controller_hazard_detect.sv
// Purely combinational stall-count calculation for the instruction in ID
// against producers in EX and MEM; zero latency.
module hazard_detect
    import pipeline_defs::*;
(
    input  logic [4:0] IIRs_i,
    input  logic [4:0] IIRt_i,
    input  logic       IDUseRt_i,
    input  logic       beq_i,
    input  logic       bne_i,
    input  logic       IEMemRead_i,
    input  logic       IERegWrite_i,
    input  logic [4:0] IERd_i,
    input  logic       EMMemRead_i,
    input  logic [4:0] EMRd_i,
    output logic [1:0] stall_n_o
);
    logic branch;
    logic ex_match;
    logic ex_live;
    logic mem_match;

    assign branch    = beq_i | bne_i;
    assign ex_match  = reg_match(IERd_i, IIRs_i, 1'b1) | reg_match(IERd_i, IIRt_i, IDUseRt_i);
    assign mem_match = reg_match(EMRd_i, IIRs_i, 1'b1) | reg_match(EMRd_i, IIRt_i, IDUseRt_i);
    // An EX register match only matters if that instruction actually produces a value.
    assign ex_live   = ex_match & (IEMemRead_i | IERegWrite_i);

    always_comb begin
        stall_n_o = 2'd0;
        if (branch) begin
            if (IEMemRead_i && ex_match)
                stall_n_o = STALL_BR_LOAD;
            else if (IERegWrite_i && ex_match)
                stall_n_o = STALL_BR_ALU;
            else if (EMMemRead_i && mem_match && !ex_live)
                stall_n_o = STALL_BR_MEMLOAD;
        end else if (IEMemRead_i && ex_match) begin
            stall_n_o = STALL_LOADUSE;
        end
    end
endmodule

// File: rtl/hazard_stall_controller.sv
// Load-use / branch-dependency stall sequencer with taken-branch/jump IF/ID flush.
// Optional perf counters (StallCycles, FlushCount) enabled by defining HAZARD_PERF_EN.
module hazard_stall_controller
    import pipeline_defs::*;
#(
    parameter int PERF_W = 32
) (
    input  logic                        clk,
    input  logic                        reset,
    hazard_stall_controller_if.slave    hif
);
    if (PERF_W < 2) begin : g_bad_perf_w
        $error("PERF_W must be at least 2");
    end

    state_e     state_q, state_d;
    logic [1:0] rem_q, rem_d;
    logic [1:0] stall_n;
    logic       pc_write;
    logic       ifid_write;
    logic       idex_bubble;
    logic       ifid_flush;
    logic       stall_active;

    hazard_detect u_detect (
        .IIRs_i       (hif.IIRs),
        .IIRt_i       (hif.IIRt),
        .IDUseRt_i    (hif.IDUseRt),
        .beq_i        (hif.beq),
        .bne_i        (hif.bne),
        .IEMemRead_i  (hif.IEMemRead),
        .IERegWrite_i (hif.IERegWrite),
        .IERd_i       (hif.IERd),
        .EMMemRead_i  (hif.EMMemRead),
        .EMRd_i       (hif.EMRd),
        .stall_n_o    (stall_n)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= ST_RUN;
            rem_q   <= 2'd0;
        end else begin
            state_q <= state_d;
            rem_q   <= rem_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        rem_d        = rem_q;
        pc_write     = 1'b1;
        ifid_write   = 1'b1;
        idex_bubble  = 1'b0;
        ifid_flush   = 1'b0;
        stall_active = 1'b0;
        if (reset) begin
            state_d     = ST_RUN;
            rem_d       = 2'd0;
            pc_write    = 1'b0;
            ifid_write  = 1'b0;
            idex_bubble = 1'b1;
        end else begin
            case (state_q)
                ST_RUN: begin
                    if (stall_n != 2'd0) begin
                        // First stall cycle is spent here; a branch is re-resolved afterwards.
                        pc_write    = 1'b0;
                        ifid_write  = 1'b0;
                        idex_bubble = 1'b1;
                        if (stall_n > 2'd1) begin
                            state_d = ST_STALL;
                            rem_d   = stall_n - 2'd1;
                        end
                    end else begin
                        ifid_flush = hif.jump | ((hif.beq | hif.bne) & hif.BrTaken);
                    end
                end
                ST_STALL: begin
                    pc_write     = 1'b0;
                    ifid_write   = 1'b0;
                    idex_bubble  = 1'b1;
                    stall_active = 1'b1;
                    if (rem_q <= 2'd1) begin
                        state_d = ST_RUN;
                        rem_d   = 2'd0;
                    end else begin
                        rem_d = rem_q - 2'd1;
                    end
                end
                default: begin
                    state_d = ST_RUN;
                    rem_d   = 2'd0;
                end
            endcase
        end
    end

    assign hif.PCWrite     = pc_write;
    assign hif.IFIDWrite   = ifid_write;
    assign hif.IDEXBubble  = idex_bubble;
    assign hif.IFIDFlush   = ifid_flush;
    assign hif.StallActive = stall_active;

`ifdef HAZARD_PERF_EN
    logic [PERF_W-1:0] stall_cycles_q;
    logic [PERF_W-1:0] flush_count_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            stall_cycles_q <= '0;
            flush_count_q  <= '0;
        end else begin
            if (!pc_write && (stall_cycles_q != '1))
                stall_cycles_q <= stall_cycles_q + 1'b1;
            if (ifid_flush && (flush_count_q != '1))
                flush_count_q <= flush_count_q + 1'b1;
        end
    end

    assign hif.StallCycles = stall_cycles_q;
    assign hif.FlushCount  = flush_count_q;
`endif

endmodule

// File: tb/tb_hazard_stall_controller.sv
// Directed bench for hazard_stall_controller: single-cycle vector table plus
// hand-written multi-cycle stall, flush and mid-stall reset sequences.
module tb_hazard_stall_controller;

    typedef struct {
        string      name;
        logic [4:0] rs;
        logic [4:0] rt;
        logic       use_rt;
        logic       beq;
        logic       bne;
        logic       jump;
        logic       taken;
        logic       ie_mr;
        logic       ie_rw;
        logic [4:0] ie_rd;
        logic       em_mr;
        logic [4:0] em_rd;
        logic [4:0] exp;   // {PCWrite, IFIDWrite, IDEXBubble, IFIDFlush, StallActive}
    } vec_t;

    localparam logic [4:0] O_RUN   = 5'b11000;
    localparam logic [4:0] O_FLUSH = 5'b11010;
    localparam logic [4:0] O_STL1  = 5'b00100;
    localparam logic [4:0] O_STL2  = 5'b00101;
    localparam logic [4:0] O_RST   = 5'b00100;

    logic clk = 1'b0;
    logic reset;
    int   checks = 0;
    int   errors = 0;
    vec_t vecs[16];

    hazard_stall_controller_if #(.PERF_W(32)) hif();

    hazard_stall_controller #(.PERF_W(32)) dut (
        .clk   (clk),
        .reset (reset),
        .hif   (hif.slave)
    );

    always #5 clk = ~clk;

    function automatic vec_t mk(input string nm, input logic [4:0] rs, input logic [4:0] rt,
                                input logic use_rt, input logic beq, input logic bne,
                                input logic jump, input logic taken, input logic ie_mr,
                                input logic ie_rw, input logic [4:0] ie_rd, input logic em_mr,
                                input logic [4:0] em_rd, input logic [4:0] exp);
        vec_t v;
        v.name = nm; v.rs = rs; v.rt = rt; v.use_rt = use_rt; v.beq = beq; v.bne = bne;
        v.jump = jump; v.taken = taken; v.ie_mr = ie_mr; v.ie_rw = ie_rw; v.ie_rd = ie_rd;
        v.em_mr = em_mr; v.em_rd = em_rd; v.exp = exp;
        return v;
    endfunction

    task automatic drive(input vec_t v);
        hif.IIRs       = v.rs;
        hif.IIRt       = v.rt;
        hif.IDUseRt    = v.use_rt;
        hif.beq        = v.beq;
        hif.bne        = v.bne;
        hif.jump       = v.jump;
        hif.BrTaken    = v.taken;
        hif.IEMemRead  = v.ie_mr;
        hif.IERegWrite = v.ie_rw;
        hif.IERd       = v.ie_rd;
        hif.EMMemRead  = v.em_mr;
        hif.EMRd       = v.em_rd;
    endtask

    task automatic check(input string nm, input logic [4:0] exp);
        logic [4:0] got;
        got = {hif.PCWrite, hif.IFIDWrite, hif.IDEXBubble, hif.IFIDFlush, hif.StallActive};
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got PCW/IFW/BUB/FLU/STA=%b expected %b", nm, got, exp);
        end
    endtask

`ifdef HAZARD_PERF_EN
    task automatic check_perf(input string nm, input logic [31:0] exp_stall,
                              input logic [31:0] exp_flush);
        checks++;
        if (hif.StallCycles !== exp_stall || hif.FlushCount !== exp_flush) begin
            errors++;
            $display("FAIL %s got stall=%0d flush=%0d expected stall=%0d flush=%0d",
                     nm, hif.StallCycles, hif.FlushCount, exp_stall, exp_flush);
        end
    endtask
`endif

    task automatic step(input vec_t v);
        @(negedge clk);
        drive(v);
        #1;
        check(v.name, v.exp);
    endtask

    initial begin
        vec_t idle;
        vec_t v;
        idle = mk("idle", 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 5'd0, O_RUN);

        //          name          rs     rt     use  beq  bne  jmp  tkn  iemr iew  ierd   emmr emrd   exp
        vecs[0]  = mk("add_nohaz",  5'd2,  5'd4,  1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0,  1'b0, 5'd0,  O_RUN);
        vecs[1]  = mk("bne_alu_ex", 5'd7,  5'd0,  1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 5'd7,  1'b0, 5'd0,  O_STL1);
        vecs[2]  = mk("bne_alu_r0", 5'd7,  5'd0,  1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 5'd0,  1'b0, 5'd0,  O_RUN);
        vecs[3]  = mk("sw_lu_rt",   5'd9,  5'd8,  1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 5'd8,  1'b0, 5'd0,  O_STL1);
        vecs[4]  = mk("addi_rt_nu", 5'd9,  5'd8,  1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 5'd8,  1'b0, 5'd0,  O_RUN);
        vecs[5]  = mk("jump_clean", 5'd1,  5'd2,  1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 5'd0,  1'b0, 5'd0,  O_FLUSH);
        vecs[6]  = mk("jump_lu",    5'd3,  5'd2,  1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 5'd3,  1'b0, 5'd0,  O_STL1);
        vecs[7]  = mk("beq_taken",  5'd1,  5'd2,  1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 5'd0,  1'b0, 5'd0,  O_FLUSH);
        vecs[8]  = mk("beq_ntaken", 5'd1,  5'd2,  1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0,  1'b0, 5'd0,  O_RUN);
        vecs[9]  = mk("beq_memld",  5'd4,  5'd2,  1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 5'd0,  1'b1, 5'd4,  O_STL1);
        vecs[10] = mk("beq_memr0",  5'd0,  5'd2,  1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0,  1'b1, 5'd0,  O_RUN);
        vecs[11] = mk("add_fwd_ex", 5'd5,  5'd1,  1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 5'd5,  1'b0, 5'd0,  O_RUN);
        vecs[12] = mk("lw_r0_use",  5'd0,  5'd0,  1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 5'd0,  1'b0, 5'd0,  O_RUN);
        vecs[13] = mk("add_memld",  5'd1,  5'd6,  1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0,  1'b1, 5'd6,  O_RUN);
        vecs[14] = mk("beq_alu_rt", 5'd1,  5'd6,  1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 5'd6,  1'b0, 5'd0,  O_STL1);
        vecs[15] = mk("bne_r0_nu",  5'd3,  5'd6,  1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 5'd6,  1'b0, 5'd0,  O_RUN);

        reset = 1'b1;
        drive(idle);
        repeat (2) @(negedge clk);
        #1;
        check("reset_state", O_RST);
`ifdef HAZARD_PERF_EN
        check_perf("reset_perf", 32'd0, 32'd0);
`endif
        @(negedge clk);
        reset = 1'b0;
        #1;
        check("post_reset_run", O_RUN);

        foreach (vecs[i]) step(vecs[i]);
        step(idle);

        // Load-use: one bubble, then the load has moved into MEM.
        step(mk("lu_c0", 5'd2, 5'd4, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 5'd2, 1'b0, 5'd0, O_STL1));
        step(mk("lu_c1", 5'd2, 5'd4, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b1, 5'd2, O_RUN));

        // Branch on a load in EX: two stall cycles, then re-resolve and flush once.
        v = mk("bl_c0", 5'd5, 5'd6, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 5'd5, 1'b0, 5'd0, O_STL1);
        step(v);
        v.name = "bl_c1_masked"; v.exp = O_STL2;
        step(v);
        step(mk("bl_c2_flush", 5'd5, 5'd6, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 5'd0, 1'b0, 5'd0, O_FLUSH));
        step(mk("bl_c3_run", 5'd1, 5'd2, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 5'd0, O_RUN));

        // Reset arriving in the second stall cycle abandons the stall immediately.
        v.name = "rs_c0"; v.exp = O_STL1;
        v.taken = 1'b0; v.ie_mr = 1'b1; v.ie_rw = 1'b1; v.ie_rd = 5'd5; v.beq = 1'b1;
        step(v);
        v.name = "rs_c1"; v.exp = O_STL2;
        step(v);
        reset = 1'b1;
        #1;
        check("rs_mid_reset", O_RST);
`ifdef HAZARD_PERF_EN
        check_perf("rs_perf_clear", 32'd0, 32'd0);
`endif
        @(negedge clk);
        reset = 1'b0;
        drive(idle);
        #1;
        check("rs_release", O_RUN);
        step(idle);

`ifdef HAZARD_PERF_EN
        step(mk("pf_jump", 5'd1, 5'd2, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 5'd0, O_FLUSH));
        step(mk("pf_lu", 5'd2, 5'd4, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 5'd2, 1'b0, 5'd0, O_STL1));
        step(idle);
        check_perf("perf_counts", 32'd1, 32'd1);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/hazard_stall_controller.md
Name: hazard_stall_controller

Overview:
- Stall/flush sequencer for the 5-stage MIPS pipeline, sitting beside the forwarding unit.
- Detects hazards that forwarding cannot cover: load-use, and a branch resolved in ID that depends on an in-flight result.
- Holds PC and IF/ID for a computed number of cycles and injects bubbles into ID/EX.
- Flushes IF/ID on a taken branch or jump.

Parameters:
- PERF_W, 32, width of the optional performance counters.

Ports:
- clk  in  1  pipeline clock
- reset  in  1  asynchronous, active-high reset
- IIRs  in  5  rs field of the instruction in ID
- IIRt  in  5  rt field of the instruction in ID
- IDUseRt  in  1  ID instruction reads rt as a source (R-type, beq, bne, sw)
- beq  in  1  ID instruction is beq
- bne  in  1  ID instruction is bne
- jump  in  1  ID instruction is j/jal
- BrTaken  in  1  ID branch comparator result (after FwA/FwB)
- IEMemRead  in  1  EX instruction is a load
- IERegWrite  in  1  EX instruction writes a register
- IERd  in  5  EX destination register (after RegDst mux)
- EMMemRead  in  1  MEM instruction is a load
- EMRd  in  5  MEM destination register
- PCWrite  out  1  1 = PC may update
- IFIDWrite  out  1  1 = IF/ID may update
- IDEXBubble  out  1  1 = zero the ID/EX control fields
- IFIDFlush  out  1  1 = IF/ID loads a nop on the next edge
- StallActive  out  1  1 = FSM is in STALL

Behaviour:
- State
  - States: RUN and STALL.
  - Registered 2-bit counter Rem; state RUN and Rem=0 at reset.
- Reset
  - While reset is high: PCWrite=0, IFIDWrite=0, IDEXBubble=1, IFIDFlush=0, StallActive=0.
  - Reset asserted mid-stall abandons the stall. The first cycle after release is RUN.
- Matching rules
  - mRs = (X != 0) and (X == IIRs).
  - mRt = (X != 0) and (X == IIRt) and IDUseRt.
  - X is either IERd or EMRd.
- Required stall count N, evaluated combinationally in RUN only:
  - Branch (beq|bne) with IEMemRead and a match on IERd: N=2.
  - Branch with IERegWrite, no IEMemRead, and a match on IERd: N=1.
  - Branch with EMMemRead and a match on EMRd, when no EX match: N=1.
  - Non-branch with IEMemRead and a match on IERd (load-use): N=1.
  - Otherwise N=0.
- RUN behaviour
  - N=0: PCWrite=1, IFIDWrite=1, IDEXBubble=0.
  - N=0: IFIDFlush = jump or ((beq|bne) and BrTaken).
  - N>0: the current cycle is stall cycle 1. PCWrite=0, IFIDWrite=0, IDEXBubble=1, IFIDFlush=0.
  - N>0: next state is RUN if N=1; otherwise STALL with Rem=N-1.
- STALL behaviour
  - Outputs: PCWrite=0, IFIDWrite=0, IDEXBubble=1, IFIDFlush=0, StallActive=1.
  - Hazard detection is masked.
  - Rem decrements each cycle; exit to RUN when Rem reaches 1.
- Simultaneous hazard and taken branch/jump: the stall wins and no flush is issued that cycle. The branch re-resolves in the RUN cycle after the stall.
- Register $0 never causes a stall.
- Latency: combinational outputs with zero latency in RUN. Outputs in STALL depend on registered state only.
- Worst-case stall is 2 cycles; Rem never exceeds 1.

Optional Feature:
- Macro: HAZARD_PERF_EN.
- Defined: adds output StallCycles [PERF_W-1:0] and output FlushCount [PERF_W-1:0].
  - StallCycles increments every cycle PCWrite=0 outside reset.
  - FlushCount increments on every IFIDFlush=1.
  - Both are cleared by reset and saturate at all-ones.
- Undefined: the ports and registers are absent; behaviour is otherwise identical.

Decomposition:
- Shared package (pipeline_defs):
  - state encodings ST_RUN=1'b0, ST_STALL=1'b1
  - REG_ZERO=5'd0
  - stall-count constants STALL_LOADUSE=2'd1, STALL_BR_ALU=2'd1, STALL_BR_LOAD=2'd2, STALL_BR_MEMLOAD=2'd1
- One natural sub-module: hazard_detect. It is purely combinational, computes N from the ID/EX/MEM fields, and is reusable by the verification model.
- The FSM, output decode and perf counters stay in the top.

Test Plan:
- lw $2 in EX (IEMemRead=1, IERd=2); add $3,$2,$4 in ID -> cycle0: PCWrite=0, IDEXBubble=1, StallActive=0; cycle1: PCWrite=1, no bubble.
- lw $5 in EX; beq $5,$6 in ID -> cycle0 and cycle1 stall (StallActive=1 in cycle1); cycle2 RUN. If BrTaken=1 in cycle2, IFIDFlush=1 there only.
- add $7 in EX (IERegWrite=1, IERd=7, IEMemRead=0); bne $7,$0 in ID -> exactly 1 stall cycle. Repeat with IERd=0 -> no stall.
- sw $8 in ID with IDUseRt=1, lw $8 in EX -> 1 stall. Same with IDUseRt=0 (addi with rt=8) -> no stall.
- jump=1, no hazard -> IFIDFlush=1, PCWrite=1 for one cycle. jump=1 with a concurrent load-use -> IFIDFlush=0, stall taken.
- Assert reset in cycle1 of a 2-cycle branch-load stall -> outputs take the reset values immediately; after release, RUN with Rem=0. With HAZARD_PERF_EN, StallCycles=0 after reset.
